// File: rtl/tft_region_if.sv
// Pixel-coordinate and region-request bundle between the TFT timing driver and the pixel mux.
// The master drives the coordinates; the slave (region decoder) returns one-hot requests and local counts.
interface tft_region_if;
  logic        tft_de;
  logic [10:0] tft_x;
  logic [10:0] tft_y;
  logic        frame_start;
  logic        tft_req_veneno;
  logic [10:0] hcount_veneno;
  logic [10:0] vcount_veneno;
  logic        tft_req_xiaofang;
  logic [10:0] hcount_xiaofang;
  logic [10:0] vcount_xiaofang;
  logic        tft_req_num;
  logic [10:0] hcount_num;
  logic [10:0] vcount_num;
  logic        tft_req_image;

  modport master (
    output tft_de, tft_x, tft_y, frame_start,
    input  tft_req_veneno, hcount_veneno, vcount_veneno,
    input  tft_req_xiaofang, hcount_xiaofang, vcount_xiaofang,
    input  tft_req_num, hcount_num, vcount_num, tft_req_image
  );

  modport slave (
    input  tft_de, tft_x, tft_y, frame_start,
    output tft_req_veneno, hcount_veneno, vcount_veneno,
    output tft_req_xiaofang, hcount_xiaofang, vcount_xiaofang,
    output tft_req_num, hcount_num, vcount_num, tft_req_image
  );
endinterface

// File: rtl/tft_region_req.sv
// Decodes active-pixel coordinates into four one-hot, registered screen-region requests.
// Define XF_MOTION_EN to build the bouncing-logo FSM; otherwise the logo sits at XF_X0/XF_Y0.
module tft_region_req #(
  parameter int H_ACT   = 800,
  parameter int V_ACT   = 480,
  parameter int VEN_X0  = 16,  parameter int VEN_Y0 = 16,
  parameter int VEN_W   = 48,  parameter int VEN_H  = 16,
  parameter int XF_X0   = 400, parameter int XF_Y0  = 200,
  parameter int XF_W    = 32,  parameter int XF_H   = 32,
  parameter int NUM_X0  = 16,  parameter int NUM_Y0 = 40,
  parameter int NUM_W   = 8,   parameter int NUM_H  = 16,
  parameter int IMG_X0  = 240, parameter int IMG_Y0 = 120,
  parameter int IMG_W   = 320, parameter int IMG_H  = 240,
  parameter int XF_STEP = 2
) (
  input  logic         clk_vga,
  input  logic         rst,
  tft_region_if.slave  bus
);

  localparam logic [1:0] DOWN_RIGHT = 2'b00;
  localparam logic [1:0] DOWN_LEFT  = 2'b01;
  localparam logic [1:0] UP_RIGHT   = 2'b10;
  localparam logic [1:0] UP_LEFT    = 2'b11;

  localparam logic [10:0] XF_X0_C = 11'(XF_X0);
  localparam logic [10:0] XF_Y0_C = 11'(XF_Y0);

  function automatic logic in_rect(input logic [11:0] px, input logic [11:0] py,
                                   input logic [11:0] x0, input logic [11:0] y0,
                                   input logic [11:0] w,  input logic [11:0] h);
    return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + h);
  endfunction

  logic [10:0] xf_x, xf_y;

`ifdef XF_MOTION_EN
  localparam logic [11:0] STEP  = 12'(XF_STEP);
  localparam logic [10:0] X_MAX = 11'(H_ACT - XF_W);
  localparam logic [10:0] Y_MAX = 11'(V_ACT - XF_H);

  logic [10:0] xf_x_q, xf_x_d, xf_y_q, xf_y_d;
  logic [1:0]  dir_q, dir_d;
  logic        left_c, up_c, left_n, up_n;

  always_comb begin
    left_c = (dir_q == DOWN_LEFT) || (dir_q == UP_LEFT);
    up_c   = (dir_q == UP_RIGHT)  || (dir_q == UP_LEFT);
    left_n = left_c;
    up_n   = up_c;
    xf_x_d = xf_x_q;
    xf_y_d = xf_y_q;
    if (bus.frame_start) begin
      // Clamp to the edge on overshoot and reverse that axis in the same update.
      if (!left_c) begin
        if ({1'b0, xf_x_q} + STEP > {1'b0, X_MAX}) begin xf_x_d = X_MAX; left_n = 1'b1; end
        else xf_x_d = xf_x_q + STEP[10:0];
      end else if ({1'b0, xf_x_q} < STEP) begin xf_x_d = '0; left_n = 1'b0; end
      else xf_x_d = xf_x_q - STEP[10:0];
      if (!up_c) begin
        if ({1'b0, xf_y_q} + STEP > {1'b0, Y_MAX}) begin xf_y_d = Y_MAX; up_n = 1'b1; end
        else xf_y_d = xf_y_q + STEP[10:0];
      end else if ({1'b0, xf_y_q} < STEP) begin xf_y_d = '0; up_n = 1'b0; end
      else xf_y_d = xf_y_q - STEP[10:0];
    end
    case ({up_n, left_n})
      2'b00:   dir_d = DOWN_RIGHT;
      2'b01:   dir_d = DOWN_LEFT;
      2'b10:   dir_d = UP_RIGHT;
      default: dir_d = UP_LEFT;
    endcase
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      xf_x_q <= XF_X0_C;
      xf_y_q <= XF_Y0_C;
      dir_q  <= DOWN_RIGHT;
    end else begin
      xf_x_q <= xf_x_d;
      xf_y_q <= xf_y_d;
      dir_q  <= dir_d;
    end
  end

  assign xf_x = xf_x_q;
  assign xf_y = xf_y_q;
`else
  assign xf_x = XF_X0_C;
  assign xf_y = XF_Y0_C;
`endif

  logic [11:0] px, py;
  logic        hit_ven, hit_xf, hit_num, hit_img;
  logic        req_ven_d, req_xf_d, req_num_d, req_img_d;
  logic        req_ven_q, req_xf_q, req_num_q, req_img_q;
  logic [10:0] hv_d, vv_d, hx_d, vx_d, hn_d, vn_d;
  logic [10:0] hv_q, vv_q, hx_q, vx_q, hn_q, vn_q;

  assign px      = {1'b0, bus.tft_x};
  assign py      = {1'b0, bus.tft_y};
  assign hit_ven = in_rect(px, py, 12'(VEN_X0), 12'(VEN_Y0), 12'(VEN_W), 12'(VEN_H));
  assign hit_xf  = in_rect(px, py, {1'b0, xf_x}, {1'b0, xf_y}, 12'(XF_W), 12'(XF_H));
  assign hit_num = in_rect(px, py, 12'(NUM_X0), 12'(NUM_Y0), 12'(NUM_W), 12'(NUM_H));
  assign hit_img = in_rect(px, py, 12'(IMG_X0), 12'(IMG_Y0), 12'(IMG_W), 12'(IMG_H));

  // Priority chain keeps the requests one-hot; only the winner gets non-zero counts.
  always_comb begin
    {req_ven_d, req_xf_d, req_num_d, req_img_d} = '0;
    {hv_d, vv_d, hx_d, vx_d, hn_d, vn_d} = '0;
    if (bus.tft_de) begin
      if (hit_img) req_img_d = 1'b1;
      else if (hit_num) begin
        req_num_d = 1'b1;
        hn_d = bus.tft_x - 11'(NUM_X0);
        vn_d = bus.tft_y - 11'(NUM_Y0);
      end else if (hit_xf) begin
        req_xf_d = 1'b1;
        hx_d = bus.tft_x - xf_x;
        vx_d = bus.tft_y - xf_y;
      end else if (hit_ven) begin
        req_ven_d = 1'b1;
        hv_d = bus.tft_x - 11'(VEN_X0);
        vv_d = bus.tft_y - 11'(VEN_Y0);
      end
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      {req_ven_q, req_xf_q, req_num_q, req_img_q} <= '0;
      {hv_q, vv_q, hx_q, vx_q, hn_q, vn_q} <= '0;
    end else begin
      {req_ven_q, req_xf_q, req_num_q, req_img_q} <= {req_ven_d, req_xf_d, req_num_d, req_img_d};
      {hv_q, vv_q, hx_q, vx_q, hn_q, vn_q} <= {hv_d, vv_d, hx_d, vx_d, hn_d, vn_d};
    end
  end

  assign bus.tft_req_veneno   = req_ven_q;
  assign bus.hcount_veneno    = hv_q;
  assign bus.vcount_veneno    = vv_q;
  assign bus.tft_req_xiaofang = req_xf_q;
  assign bus.hcount_xiaofang  = hx_q;
  assign bus.vcount_xiaofang  = vx_q;
  assign bus.tft_req_num      = req_num_q;
  assign bus.hcount_num       = hn_q;
  assign bus.vcount_num       = vn_q;
  assign bus.tft_req_image    = req_img_q;

endmodule
